// File: rtl/somasub_serial.sv
// somasub_serial: nibble-serial add/subtract with accumulate mode and a multiplexed hex display of the result.
module somasub_serial #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 ctrl,
  input  logic                 acc_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic                 overflow,
  output logic [6:0]           seg,
  output logic [WIDTH/4-1:0]   dig
);
  localparam int DIGITS = WIDTH / 4;
  localparam int KW     = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW     = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d, idx_q, idx_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic             c_q, c_d, carry_q, carry_d, overflow_q, overflow_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [3:0]       nib_a, nib_b, nib_r;
  logic [4:0]       nib_s;
  logic             scan_wrap;

  // One nibble of the ripple chain per CALC cycle; carry into the MSB is recovered from the top sum bit.
  always_comb begin
    nib_a      = opa_q[{k_q, 2'b00} +: 4];
    nib_b      = opb_q[{k_q, 2'b00} +: 4];
    nib_s      = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, c_q};
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    sum_d      = sum_q;
    c_d        = c_q;
    k_d        = k_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (state_q == CALC) begin
      sum_d[{k_q, 2'b00} +: 4] = nib_s[3:0];
      c_d = nib_s[4];
      k_d = k_q + 1'b1;
      if (k_q == KW'(DIGITS - 1)) begin
        state_d    = DONE;
        done_d     = 1'b1;
        result_d   = sum_d;
        carry_d    = nib_s[4];
        overflow_d = nib_a[3] ^ nib_b[3] ^ nib_s[3] ^ nib_s[4];
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = CALC;
      opa_d   = acc_mode ? result_q : a;
      opb_d   = b ^ {WIDTH{ctrl}};
      c_d     = ctrl;
      k_d     = '0;
      busy_d  = 1'b1;
    end
  end

  always_comb begin
    scan_wrap = scan_q == SW'(SCAN_DIV - 1);
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = scan_wrap ? (idx_q == KW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    nib_r     = result_q[{idx_q, 2'b00} +: 4];
    seg       = GLYPH[nib_r];
    dig       = DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      sum_q      <= '0;
      c_q        <= 1'b0;
      k_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      sum_q      <= sum_d;
      c_q        <= c_d;
      k_q        <= k_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_somasub_serial.sv
// tb_somasub_serial: directed checks of the serial adder/subtractor at WIDTH=8, SCAN_DIV=2.
module tb_somasub_serial;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ctrl = 1'b0;
  logic       acc_mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, carry, overflow;
  logic [7:0] result;
  logic [6:0] seg;
  logic [1:0] dig;
  int         checks = 0;
  int         errors = 0;

  somasub_serial #(.WIDTH(8), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .acc_mode(acc_mode),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .carry(carry), .overflow(overflow), .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Issues one request and follows it to one edge past done, recording what was seen.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic iacc,
                       output int lat, output int busy_n, output int done_n, output logic [7:0] res_mid);
    @(negedge clk);
    a = ia; b = ib; ctrl = ic; acc_mode = iacc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = int'(busy); done_n = int'(done); res_mid = result; lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++; busy_n += int'(busy); done_n += int'(done);
    end
    @(posedge clk); #1;
    busy_n += int'(busy); done_n += int'(done);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s: got %0h expected %0h", name, got, exp); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; a = 8'h11; b = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 8'h00);
    chk("rst_carry", carry, 0); chk("rst_ovf", overflow, 0);
    chk("rst_dig", dig, 2'b01); chk("rst_seg", seg, 7'h7E);
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_ignored", busy, 0);
    chk("scan_hold", dig, 2'b01);
    @(posedge clk); #1;
    chk("scan_step", dig, 2'b10); chk("scan_seg_zero", seg, 7'h7E);
  endtask

  task automatic test_add;
    int lat, bn, dn; logic [7:0] rm;
    do_op(8'h3C, 8'h45, 1'b0, 1'b0, lat, bn, dn, rm);
    chk("add_latency", lat, 2); chk("add_busy_cycles", bn, 3); chk("add_done_pulses", dn, 1);
    chk("add_result_mid", rm, 8'h00);
    chk("add_result", result, 8'h81); chk("add_carry", carry, 0); chk("add_ovf", overflow, 1);
    chk("add_idle", busy, 0);
  endtask

  task automatic test_sub;
    int lat, bn, dn; logic [7:0] rm;
    do_op(8'h05, 8'h07, 1'b1, 1'b0, lat, bn, dn, rm);
    chk("sub1_result", result, 8'hFE); chk("sub1_carry", carry, 0); chk("sub1_ovf", overflow, 0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, lat, bn, dn, rm);
    chk("sub2_result_mid", rm, 8'hFE);
    chk("sub2_result", result, 8'h7F); chk("sub2_carry", carry, 1); chk("sub2_ovf", overflow, 1);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, lat, bn, dn, rm);
    chk("sub_zero_result", result, 8'h00); chk("sub_zero_carry", carry, 1); chk("sub_zero_ovf", overflow, 0);
  endtask

  task automatic test_boundary;
    int lat, bn, dn; logic [7:0] rm;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bn, dn, rm);
    chk("wrap_result", result, 8'h00); chk("wrap_carry", carry, 1); chk("wrap_ovf", overflow, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, lat, bn, dn, rm);
    chk("posovf_result", result, 8'h80); chk("posovf_carry", carry, 0); chk("posovf_ovf", overflow, 1);
  endtask

  task automatic test_accumulate;
    int lat, bn, dn; logic [7:0] rm;
    do_op(8'h3C, 8'h45, 1'b0, 1'b0, lat, bn, dn, rm);
    chk("acc_seed", result, 8'h81);
    do_op(8'hFF, 8'h7F, 1'b0, 1'b1, lat, bn, dn, rm);
    chk("acc_result", result, 8'h00); chk("acc_carry", carry, 1); chk("acc_ovf", overflow, 0);
    do_op(8'h00, 8'h10, 1'b1, 1'b1, lat, bn, dn, rm);
    chk("acc_sub_result", result, 8'hF0); chk("acc_sub_carry", carry, 0);
  endtask

  task automatic test_busy;
    int dn;
    @(negedge clk);
    a = 8'h12; b = 8'h34; ctrl = 1'b0; acc_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; ctrl = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = int'(done);
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; dn += int'(done); end
    chk("busy_done_pulses", dn, 1); chk("busy_result", result, 8'h46); chk("busy_idle", busy, 0);
  endtask

  task automatic test_reset_calc;
    int dn;
    @(negedge clk);
    a = 8'h3C; b = 8'h45; ctrl = 1'b0; acc_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_in_calc", busy, 1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0); chk("abort_result", result, 8'h00); chk("abort_dig", dig, 2'b01);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; dn += int'(done); end
    chk("abort_no_done", dn, 0); chk("abort_result_kept", result, 8'h00);
  endtask

  task automatic test_scan;
    int lat, bn, dn, w; logic [7:0] rm;
    do_op(8'hA0, 8'h05, 1'b0, 1'b0, lat, bn, dn, rm);
    chk("scan_result", result, 8'hA5);
    w = 0;
    while (dig !== 2'b10 && w < 10) begin @(posedge clk); #1; w++; end
    while (dig !== 2'b01 && w < 10) begin @(posedge clk); #1; w++; end
    chk("scan_found", int'(w < 10), 1);
    chk("scan0_dig", dig, 2'b01); chk("scan0_seg", seg, 7'h5B);
    @(posedge clk); #1; chk("scan1_dig", dig, 2'b01); chk("scan1_seg", seg, 7'h5B);
    @(posedge clk); #1; chk("scan2_dig", dig, 2'b10); chk("scan2_seg", seg, 7'h77);
    @(posedge clk); #1; chk("scan3_dig", dig, 2'b10); chk("scan3_seg", seg, 7'h77);
    @(posedge clk); #1; chk("scan4_dig", dig, 2'b01); chk("scan4_seg", seg, 7'h5B);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_boundary;
    test_accumulate;
    test_busy;
    test_reset_calc;
    test_scan;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
